load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the ALU/control path and the word-addressed data memory.
- Converts the ALU byte address into a word index and supports word, halfword and byte loads and stores.
- Sub-word stores use a two-cycle read-modify-write; the PC is stalled for the extra cycle.
- Load data is extracted and extended before it reaches the writeback mux.

Parameters:
- DEPTH, 52, number of 32-bit words in data memory; word indices >= DEPTH are out of range.
- AW, 32, width of the byte address and of the word index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  reset, asynchronous and active-high.
- req_valid  in  1  a memory instruction is present this cycle.
- req_op  in  3  operation: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data from rt; sub-word stores use the low bits.
- stall  out  1  hold PC and pipeline inputs this cycle.
- rdata  out  32  extended load result for writeback.
- rdata_valid  out  1  rdata is meaningful this cycle.
- align_err  out  1  misaligned access this cycle.
- range_err  out  1  word index >= DEPTH this cycle.
- err_addr  out  32  address of the first faulting access (sticky).
- mem_addr  out  32  word index, equal to addr >> 2.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable; memory writes on the rising edge.
- mem_wdata  out  32  full word to be written.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Byte order is big-endian: byte offset 0 is bits 31:24, offset 3 is bits 7:0. Halfword offset 0 is bits 31:16.
- Reset values: state IDLE, merge register 0, err_addr 0, sticky flag clear. All outputs are combinationally 0 under reset.
- States:
  - IDLE: normal operation.
  - RMW_WR: second cycle of a sub-word store.
- Errors (combinational, IDLE only, when req_valid):
  - align_err when addr[1:0]!=0 for LW/SW, or addr[0]!=0 for LH/LHU/SH.
  - range_err when (addr>>2) >= DEPTH.
  - On either error: no mem_read or mem_write, rdata = 0, rdata_valid = 0, stall = 0.
  - err_addr latches addr on the first error after reset only.
- Loads (IDLE, no error): zero extra latency.
  - mem_read = 1; rdata is combinational from mem_rdata; rdata_valid = 1.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- SW (IDLE, no error): single cycle, mem_write = 1, mem_wdata = wdata, stall = 0.
- SB/SH (IDLE, no error):
  - Cycle 1: mem_read = 1, stall = 1, merge register <= mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0]. The word index is latched; go to RMW_WR.
  - Cycle 2 (RMW_WR): mem_write = 1, mem_addr = latched index, mem_wdata = merge register, stall = 0; return to IDLE.
- In RMW_WR, req_valid, req_op and addr are ignored: the write is committed once cycle 1 completes.
- Reset asserted during RMW_WR: state returns to IDLE immediately, no write occurs, memory is unchanged.
- req_valid = 0 in IDLE: all memory strobes are 0, rdata = 0, stall = 0.
- Back-to-back accesses: a load in the cycle after an RMW write sees the updated word, because memory writes at that rising edge.

Decomposition:
- Package lsu_pkg: op encodings (OP_LW to OP_SB), state enum {IDLE, RMW_WR}, and lane-offset constants.
- Sub-module lsu_align (combinational), two functions:
  - load extract/extend from word, offset and op;
  - store merge of old word, new data, offset and op.
- The parent module holds the FSM, latches and error logic.

Test Plan:
- Word 2 = 0x11223344; LB addr 9 -> rdata 0x00000022, rdata_valid 1, stall 0. Word 3 = 0x80FF0000; LB addr 12 -> 0xFFFFFF80; LBU addr 12 -> 0x00000080; LH addr 12 -> 0xFFFF80FF.
- Word 2 = 0x11223344; SB addr 10, wdata 0x000000AA -> stall 1 for one cycle, write in cycle 2; then LW addr 8 -> 0x1122AA44. SH addr 8, wdata 0xBEEF -> word becomes 0xBEEFAA44.
- LH addr 3 -> align_err 1, rdata 0, no strobes, err_addr 3. A following SW addr 5 -> align_err 1, err_addr stays 3.
- SW addr 208 (index 52) -> range_err 1, mem_write 0. SW addr 204 -> word 51 written.
- SB addr 10, then assert reset during RMW_WR -> no mem_write, word 2 still 0x11223344, state IDLE, stall 0.
- SW addr 0 wdata 0xDEADBEEF, then immediately LW addr 0 -> rdata 0xDEADBEEF with no stall.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: memory op codes, FSM states and
// big-endian byte-lane offsets within a 32-bit word.
package lsu_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RMW_WR = 1'b1;

  // Offset 0 is the most significant byte (big-endian).
  localparam logic [1:0] OFF_B0 = 2'd0;
  localparam logic [1:0] OFF_B1 = 2'd1;
  localparam logic [1:0] OFF_B2 = 2'd2;
  localparam logic [1:0] OFF_B3 = 2'd3;

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory signals of the load/store unit.
interface lsu_if #(parameter int AW = 32);
  logic          req_valid;
  logic [2:0]    req_op;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          stall;
  logic [31:0]   rdata;
  logic          rdata_valid;
  logic          align_err;
  logic          range_err;
  logic [AW-1:0] err_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  req_valid, req_op, addr, wdata, mem_rdata,
    output stall, rdata, rdata_valid, align_err, range_err, err_addr,
           mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_op, addr, wdata, mem_rdata,
    input  stall, rdata, rdata_valid, align_err, range_err, err_addr,
           mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Lane steering: load extract/extend and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_data_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  op_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  off,
                                               input logic [2:0]  op);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      OFF_B0:  b = w[31:24];
      OFF_B1:  b = w[23:16];
      OFF_B2:  b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (op)
      OP_LH:   load_extract = {{16{h[15]}}, h};
      OP_LHU:  load_extract = {16'h0000, h};
      OP_LB:   load_extract = {{24{b[7]}}, b};
      OP_LBU:  load_extract = {24'h000000, b};
      default: load_extract = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] d,
                                              input logic [1:0]  off,
                                              input logic [2:0]  op);
    logic [31:0] m;
    m = old;
    case (op)
      OP_SH: begin
        if (off[1]) m[15:0] = d[15:0];
        else        m[31:16] = d[15:0];
      end
      OP_SB: begin
        case (off)
          OFF_B0:  m[31:24] = d[7:0];
          OFF_B1:  m[23:16] = d[7:0];
          OFF_B2:  m[15:8]  = d[7:0];
          default: m[7:0]   = d[7:0];
        endcase
      end
      default: m = d;
    endcase
    store_merge = m;
  endfunction

  assign load_data_o  = load_extract(old_word_i, offset_i, op_i);
  assign merge_data_o = store_merge(old_word_i, new_data_i, offset_i, op_i);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: word-index translation, error detection, and a two-cycle
// read-modify-write for byte/halfword stores against a word-wide memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 52,
  parameter int AW    = 32
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);

  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  logic [0:0]    state_q, state_d;
  logic [31:0]   merge_q, merge_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic          err_seen_q, err_seen_d;

  logic [AW-1:0] word_idx_s;
  logic          align_s, range_s, is_load_s, is_sw_s, is_sub_s;
  logic [31:0]   load_data_s, merge_data_s;

  assign word_idx_s = bus.addr >> 2;
  assign range_s    = (word_idx_s >= DEPTH_W);
  assign is_load_s  = (bus.req_op <= OP_LBU);
  assign is_sw_s    = (bus.req_op == OP_SW);
  assign is_sub_s   = (bus.req_op == OP_SH) || (bus.req_op == OP_SB);

  lsu_align u_align (
    .old_word_i   (bus.mem_rdata),
    .new_data_i   (bus.wdata),
    .offset_i     (bus.addr[1:0]),
    .op_i         (bus.req_op),
    .load_data_o  (load_data_s),
    .merge_data_o (merge_data_s)
  );

  always_comb begin
    case (bus.req_op)
      OP_LW, OP_SW:         align_s = (bus.addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: align_s = bus.addr[0];
      default:              align_s = 1'b0;
    endcase
  end

  always_comb begin
    bus.stall       = 1'b0;
    bus.rdata       = 32'h0000_0000;
    bus.rdata_valid = 1'b0;
    bus.align_err   = 1'b0;
    bus.range_err   = 1'b0;
    bus.err_addr    = reset ? '0 : err_addr_q;
    bus.mem_addr    = '0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_wdata   = 32'h0000_0000;
    state_d         = state_q;
    merge_d         = merge_q;
    idx_d           = idx_q;
    err_addr_d      = err_addr_q;
    err_seen_d      = err_seen_q;
    if (reset) begin
      state_d = IDLE;
    end else if (state_q == RMW_WR) begin
      // Commit the merged word regardless of the new request inputs.
      bus.mem_write = 1'b1;
      bus.mem_addr  = idx_q;
      bus.mem_wdata = merge_q;
      state_d       = IDLE;
    end else if (bus.req_valid) begin
      bus.mem_addr  = word_idx_s;
      bus.align_err = align_s;
      bus.range_err = range_s;
      if (align_s || range_s) begin
        if (!err_seen_q) begin
          err_addr_d = bus.addr;
          err_seen_d = 1'b1;
        end else begin
          err_addr_d = err_addr_q;
        end
      end else if (is_load_s) begin
        bus.mem_read    = 1'b1;
        bus.rdata       = load_data_s;
        bus.rdata_valid = 1'b1;
      end else if (is_sw_s) begin
        bus.mem_write = 1'b1;
        bus.mem_wdata = bus.wdata;
      end else if (is_sub_s) begin
        bus.mem_read = 1'b1;
        bus.stall    = 1'b1;
        merge_d      = merge_data_s;
        idx_d        = word_idx_s;
        state_d      = RMW_WR;
      end else begin
        state_d = IDLE;
      end
    end else begin
      state_d = IDLE;
    end
  end

  // State, merge buffer, latched index and sticky error address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      merge_q    <= 32'h0000_0000;
      idx_q      <= '0;
      err_addr_q <= '0;
      err_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      merge_q    <= merge_d;
      idx_q      <= idx_d;
      err_addr_q <= err_addr_d;
      err_seen_q <= err_seen_d;
    end
  end

endmodule
